// File: rtl/time_pkg.sv
// time_pkg: shared mode encodings, field limits and small helpers for time_keeper.
package time_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_HOUR  = 3'd1,
        SET_MIN   = 3'd2,
        SET_AHOUR = 3'd3,
        SET_AMIN  = 3'd4
    } mode_t;

    localparam logic [5:0] MAX_SEC        = 6'd59;
    localparam logic [5:0] MAX_MIN        = 6'd59;
    localparam logic [5:0] MAX_HOUR       = 6'd23;
    localparam logic [5:0] ALARM_RST_HOUR = 6'd7;
    localparam logic [5:0] ALARM_RST_MIN  = 6'd0;

    // Increment with wrap to zero after the field maximum.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] maxv);
        return (v == maxv) ? 6'd0 : v + 6'd1;
    endfunction

    // Modes in which the clock itself is frozen for editing.
    function automatic logic is_set_time(input mode_t m);
        return (m == SET_HOUR) || (m == SET_MIN);
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// btn_pulse: 2-flop synchronizer followed by a rising-edge detector.
// The pulse is high for one cycle, in the cycle after the second sync flop goes high.
module btn_pulse (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    // Synchronize the asynchronous level and keep one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/time_keeper.sv
// time_keeper: 24h clock with button-driven time/alarm setting.
// Optional alarm setting is enabled by defining TIME_KEEPER_ALARM_SET_EN;
// without it the alarm outputs are the constant reset values.
module time_keeper
    import time_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [5:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [5:0] orihour,
    output logic [5:0] orimin,
    output logic [2:0] mode,
    output logic       tick
);

    localparam int            PW        = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [1:0] btn_vec;
    logic [1:0] pulse_vec;
    logic       mode_pulse;
    logic       inc_pulse;

    mode_t         mode_reg,  mode_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [5:0]    hour_reg,  hour_next;
    logic [5:0]    min_reg,   min_next;
    logic [5:0]    sec_reg,   sec_next;
    logic          tick_reg,  tick_next;
    logic          leave_set_min;

    assign btn_vec = {inc_btn, mode_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_pulse u_btn (
                .clk   (clk),
                .rst   (rst),
                .btn   (btn_vec[gi]),
                .pulse (pulse_vec[gi])
            );
        end
    endgenerate

    // A mode press in the same cycle wins over an increment press.
    assign mode_pulse = pulse_vec[0];
    assign inc_pulse  = pulse_vec[1] & ~pulse_vec[0];

    // Mode sequencing; alarm-setting states only exist in the alarm build.
    always_comb begin
        mode_next = mode_reg;
        if (mode_pulse) begin
            case (mode_reg)
                RUN:       mode_next = SET_HOUR;
                SET_HOUR:  mode_next = SET_MIN;
`ifdef TIME_KEEPER_ALARM_SET_EN
                SET_MIN:   mode_next = SET_AHOUR;
                SET_AHOUR: mode_next = SET_AMIN;
                SET_AMIN:  mode_next = RUN;
`else
                SET_MIN:   mode_next = RUN;
`endif
                default:   mode_next = RUN;
            endcase
        end
    end

    assign leave_set_min = (mode_reg == SET_MIN) && (mode_next != SET_MIN);

    // Prescaler, time-of-day counters with carry chain, and field edits.
    always_comb begin
        presc_next = presc_reg;
        sec_next   = sec_reg;
        min_next   = min_reg;
        hour_next  = hour_reg;

        // The prescaler is parked at 0 while editing and restarts on exit.
        if (is_set_time(mode_next) || leave_set_min) begin
            presc_next = '0;
        end else if (presc_reg == PRESC_MAX) begin
            presc_next = '0;
        end else begin
            presc_next = presc_reg + PW'(1);
        end

        // tick_reg is never high in the edit modes, so the two branches never collide.
        if (tick_reg) begin
            sec_next = wrap_inc(sec_reg, MAX_SEC);
            if (sec_reg == MAX_SEC) begin
                min_next = wrap_inc(min_reg, MAX_MIN);
                if (min_reg == MAX_MIN) begin
                    hour_next = wrap_inc(hour_reg, MAX_HOUR);
                end
            end
        end else if (inc_pulse) begin
            if (mode_reg == SET_HOUR) begin
                hour_next = wrap_inc(hour_reg, MAX_HOUR);
            end else if (mode_reg == SET_MIN) begin
                min_next = wrap_inc(min_reg, MAX_MIN);
            end
        end

        if (leave_set_min) begin
            sec_next = '0;
        end

        tick_next = (presc_next == PRESC_MAX) && !is_set_time(mode_next);
    end

    // State registers for mode, prescaler and time of day.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg  <= RUN;
            presc_reg <= '0;
            hour_reg  <= '0;
            min_reg   <= '0;
            sec_reg   <= '0;
            tick_reg  <= 1'b0;
        end else begin
            mode_reg  <= mode_next;
            presc_reg <= presc_next;
            hour_reg  <= hour_next;
            min_reg   <= min_next;
            sec_reg   <= sec_next;
            tick_reg  <= tick_next;
        end
    end

`ifdef TIME_KEEPER_ALARM_SET_EN
    logic [5:0] ahour_reg, ahour_next;
    logic [5:0] amin_reg,  amin_next;

    // Alarm fields only change on an increment in their own edit mode.
    always_comb begin
        ahour_next = ahour_reg;
        amin_next  = amin_reg;
        if (inc_pulse && (mode_reg == SET_AHOUR)) begin
            ahour_next = wrap_inc(ahour_reg, MAX_HOUR);
        end
        if (inc_pulse && (mode_reg == SET_AMIN)) begin
            amin_next = wrap_inc(amin_reg, MAX_MIN);
        end
    end

    // Alarm registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ahour_reg <= ALARM_RST_HOUR;
            amin_reg  <= ALARM_RST_MIN;
        end else begin
            ahour_reg <= ahour_next;
            amin_reg  <= amin_next;
        end
    end

    assign orihour = ahour_reg;
    assign orimin  = amin_reg;
`else
    assign orihour = ALARM_RST_HOUR;
    assign orimin  = ALARM_RST_MIN;
`endif

    assign hour = hour_reg;
    assign min  = min_reg;
    assign sec  = sec_reg;
    assign mode = mode_reg;
    assign tick = tick_reg;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed self-checking bench for time_keeper at CLK_HZ=10.
// Honours TIME_KEEPER_ALARM_SET_EN the same way as the design.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [5:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [5:0] orihour;
    logic [5:0] orimin;
    logic [2:0] mode;
    logic       tick;

    int vecs = 0;
    int miscompares = 0;
    int tick_total = 0;
    int t0;
    int k;

    time_keeper #(.CLK_HZ(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .orihour  (orihour),
        .orimin   (orimin),
        .mode     (mode),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // Count cycles in which tick was high (value seen just before each edge).
    always @(posedge clk) begin
        if (tick) tick_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("vec %0d %s: observed %0d expected %0d", vecs, tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic i);
        mode_btn = m;
        inc_btn  = i;
        cyc(3);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        cyc(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(2);
        chk("rst_hour", hour, 0);
        chk("rst_min", min, 0);
        chk("rst_sec", sec, 0);
        chk("rst_orihour", orihour, 7);
        chk("rst_orimin", orimin, 0);
        chk("rst_mode", mode, 0);
        chk("rst_tick", tick, 0);

        // 600 clocks of free run -> 00:01:00 with 60 ticks
        rst = 1'b0;
        t0 = tick_total;
        cyc(600);
        chk("run600_sec", sec, 0);
        chk("run600_min", min, 1);
        chk("run600_hour", hour, 0);
        chk("run600_ticks", tick_total - t0, 60);

        // Mode and inc together in RUN: mode wins
        press(1'b1, 1'b1);
        chk("both_run_mode", mode, 1);
        chk("both_run_hour", hour, 0);

        // 25 increments of hour in SET_HOUR
        t0 = tick_total;
        repeat (25) press(1'b0, 1'b1);
        chk("inc25_hour", hour, 1);
        chk("inc25_min", min, 1);
        chk("inc25_sec", sec, 0);
        chk("inc25_ticks", tick_total - t0, 0);
        repeat (22) press(1'b0, 1'b1);
        chk("preset_hour", hour, 23);

        // Mode and inc together in SET_HOUR: mode wins, hour untouched
        press(1'b1, 1'b1);
        chk("both_sethour_mode", mode, 2);
        chk("both_sethour_hour", hour, 23);
        repeat (58) press(1'b0, 1'b1);
        chk("preset_min", min, 59);
        chk("preset_hour2", hour, 23);

        // Leave SET_MIN: sec and prescaler clear, first tick after 9 cycles
        mode_btn = 1'b1;
        cyc(3);
`ifdef TIME_KEEPER_ALARM_SET_EN
        chk("exit_setmin_mode", mode, 3);
`else
        chk("exit_setmin_mode", mode, 0);
`endif
        chk("exit_setmin_sec", sec, 0);
        mode_btn = 1'b0;
        k = 0;
        while (!tick && k < 20) begin
            cyc(1);
            k++;
        end
        chk("exit_setmin_tick_delay", k, 9);
        cyc(1);
        chk("exit_setmin_sec1", sec, 1);

        // Reach 23:59:59 and roll over
        cyc(589);
        chk("pre_wrap_sec", sec, 59);
        chk("pre_wrap_min", min, 59);
        chk("pre_wrap_hour", hour, 23);
        chk("pre_wrap_tick", tick, 1);
        cyc(1);
        chk("wrap_hour", hour, 0);
        chk("wrap_min", min, 0);
        chk("wrap_sec", sec, 0);
        chk("wrap_orihour", orihour, 7);
        chk("wrap_orimin", orimin, 0);

`ifdef TIME_KEEPER_ALARM_SET_EN
        // Alarm editing: currently in SET_AHOUR
        repeat (2) press(1'b0, 1'b1);
        chk("alarm_orihour", orihour, 9);
        chk("alarm_hour_untouched", hour, 0);
        press(1'b1, 1'b0);
        chk("alarm_mode_amin", mode, 4);
        repeat (3) press(1'b0, 1'b1);
        chk("alarm_orimin", orimin, 3);
        chk("alarm_orihour_kept", orihour, 9);
        press(1'b1, 1'b0);
        chk("alarm_mode_run", mode, 0);
`else
        // Without alarm setting, the cycle is three modes long
        press(1'b1, 1'b0);
        chk("cyc3_mode1", mode, 1);
        press(1'b1, 1'b0);
        chk("cyc3_mode2", mode, 2);
        press(1'b1, 1'b0);
        chk("cyc3_mode0", mode, 0);
        chk("cyc3_orihour", orihour, 7);
        chk("cyc3_orimin", orimin, 0);
`endif

        // Reset in the middle of an hour edit
        press(1'b1, 1'b0);
        chk("midset_mode", mode, 1);
        repeat (2) press(1'b0, 1'b1);
        chk("midset_hour", hour, 2);
        inc_btn = 1'b1;
        cyc(2);
        rst = 1'b1;
        #1;
        chk("async_rst_hour", hour, 0);
        chk("async_rst_mode", mode, 0);
        chk("async_rst_orihour", orihour, 7);
        inc_btn = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(5);
        chk("post_rst_hour", hour, 0);
        chk("post_rst_mode", mode, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter: CLK_HZ, 100_000_000, input clock frequency in Hz; prescaler terminal count is CLK_HZ-1; legal range is 2 or more.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: mode_btn  input  1  asynchronous level input; each rising edge advances the mode.
REQ-005 Port: inc_btn  input  1  asynchronous level input; each rising edge increments the selected field.
REQ-006 Port: hour  output  6  current hour, 0..23.
REQ-007 Port: min  output  6  current minute, 0..59.
REQ-008 Port: sec  output  6  current second, 0..59.
REQ-009 Port: orihour  output  6  alarm hour, 0..23.
REQ-010 Port: orimin  output  6  alarm minute, 0..59.
REQ-011 Port: mode  output  3  current FSM state encoding.
REQ-012 Port: tick  output  1  one-cycle pulse at each 1 Hz second boundary.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer and then a rising-edge detector, giving one single-cycle pulse per press; the field or mode update SHALL be visible on the 3rd rising clk edge after the first edge that samples the input high.
REQ-014 The prescaler SHALL count 0..CLK_HZ-1 and wrap to 0; tick SHALL be high only in the cycle where prescaler==CLK_HZ-1 and the mode is not SET_HOUR or SET_MIN.
REQ-015 On the edge that ends a tick cycle: sec increments; sec 59->0 carries into min; min 59->0 with carry carries into hour; hour 23->0 wraps with no further carry (23:59:59 -> 00:00:00).
REQ-016 FSM states SHALL be RUN=0, SET_HOUR=1, SET_MIN=2, SET_AHOUR=3, SET_AMIN=4; a mode pulse advances RUN->SET_HOUR->SET_MIN->SET_AHOUR->SET_AMIN->RUN.
REQ-017 In SET_HOUR and SET_MIN, the prescaler SHALL hold at 0 and sec SHALL hold its value.
REQ-018 On the transition out of SET_MIN, sec and the prescaler SHALL clear to 0.
REQ-019 An inc pulse SHALL increment only the field selected by the mode (hour, min, orihour, or orimin), with wrap 23->0 or 59->0 and no carry into any other field; in RUN it SHALL be ignored.
REQ-020 In SET_AHOUR and SET_AMIN, timekeeping SHALL continue normally.
REQ-021 If mode and inc pulses occur in the same cycle, the mode pulse SHALL win and the inc pulse SHALL be discarded.
REQ-022 If an inc pulse on hour or min coincides with a tick carry in SET_AHOUR or SET_AMIN, it has no effect on hour or min; the carry applies.
REQ-023 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-024 Asserting rst SHALL immediately force: hour=min=sec=0, orihour=7, orimin=0, mode=RUN, tick=0, prescaler=0, synchronizers and edge detectors cleared.
REQ-025 Reset asserted mid-set SHALL abandon the set operation; no partially incremented value persists.
REQ-026 The first tick after reset release SHALL occur CLK_HZ cycles after the first active edge.

Configuration
REQ-027 Macro TIME_KEEPER_ALARM_SET_EN:
- Defined: SET_AHOUR and SET_AMIN exist as in REQ-016.
- Undefined: the sequence is RUN->SET_HOUR->SET_MIN->RUN; orihour and orimin are constant 7 and 0; no alarm registers are synthesized.

Structure
REQ-028 Package time_pkg SHALL hold: mode state enum/encodings, MAX_SEC=59, MAX_MIN=59, MAX_HOUR=23, ALARM_RST_HOUR=7, ALARM_RST_MIN=0.
REQ-029 One sub-module btn_pulse (synchronizer plus edge detector) SHALL be instantiated twice, once per button.

Verification (CLK_HZ=10)
REQ-030 Reset release, run 600 clocks -> sec=0, min=1, hour=0; tick pulses counted = 60.
REQ-031 Time preset to 23:59:59, one tick -> 00:00:00 on the same edge; orihour/orimin unchanged.
REQ-032 Mode pulse x1, inc x25 -> hour=1; min unchanged; sec frozen; tick stays 0.
REQ-033 Mode x2 (reach SET_MIN) with prescaler mid-count, then mode x1 -> sec=0, prescaler=0, mode=SET_AHOUR; next tick after exactly 10 clocks.
REQ-034 Mode and inc rising on the same cycle in RUN -> mode=SET_HOUR; hour unchanged.
REQ-035 With TIME_KEEPER_ALARM_SET_EN undefined, mode x3 -> mode=RUN; orihour=7, orimin=0 throughout.
